// File: rtl/tx_fifo_buffer_pkg.sv
// Shared types and constants for the transmit FIFO / frame buffer.
// The frame FSM state and the FRAME_MODE encodings live here.
package tx_fifo_buffer_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } frame_state_e;

  localparam int MODE_STREAM = 0;
  localparam int MODE_FRAME  = 1;

endpackage

// File: rtl/tx_buffer_mem.sv
// Word storage for the transmit buffer: one synchronous write port and
// one asynchronous read port, no reset on the array.
module tx_buffer_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tx_fifo_buffer.sv
// Transmit buffer: a first-word-fall-through stream FIFO, or (FRAME_MODE=1)
// an addressed frame buffer that fills by slot and then drains in order.
module tx_fifo_buffer
  import tx_fifo_buffer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int FRAME_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] address,
  input  logic              commit,
  input  logic              rd,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam bit              IS_FRAME  = (FRAME_MODE == MODE_FRAME);

  frame_state_e      r_state;
  logic [ADDR_W-1:0] r_wPtr;
  logic [ADDR_W-1:0] r_rPtr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_len;
  logic [DEPTH-1:0]  r_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_empty;
  logic              w_full;
  logic              w_wrAccept;
  logic              w_rdAccept;
  logic              w_startDrain;
  logic              w_lastRead;
  logic [ADDR_W-1:0] w_memWaddr;
  logic [DATA_W-1:0] w_memRdata;
  logic [DEPTH-1:0]  w_validNext;

  function automatic logic [ADDR_W:0] countOnes(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) n = n + (ADDR_W+1)'(v[i]);
    return n;
  endfunction

  // Frame length runs up to the highest written slot; lower holes read as zero.
  function automatic logic [ADDR_W:0] frameLen(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (v[i]) n = (ADDR_W+1)'(i + 1);
    end
    return n;
  endfunction

  always_comb begin
    w_empty     = 1'b1;
    w_full      = 1'b0;
    w_wrAccept  = 1'b0;
    w_rdAccept  = 1'b0;
    w_memWaddr  = r_wPtr;
    if (IS_FRAME) begin
      w_empty    = (r_state == FILL);
      w_full     = (r_state == DRAIN);
      w_wrAccept = wr && (r_state == FILL);
      w_rdAccept = rd && (r_state == DRAIN);
      w_memWaddr = address;
    end else begin
      w_empty    = (r_count == '0);
      w_full     = (r_count == DEPTH_CNT);
      w_wrAccept = wr && (!w_full || rd);
      w_rdAccept = rd && !w_empty;
    end
    w_validNext = r_valid;
    if (w_wrAccept) w_validNext[address] = 1'b1;
    w_startDrain = (r_state == FILL) && ((&r_valid) || (commit && (r_count != '0)));
    w_lastRead   = w_rdAccept && ({1'b0, r_rPtr} == (r_len - 1'b1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= FILL;
      r_wPtr      <= '0;
      r_rPtr      <= '0;
      r_count     <= '0;
      r_len       <= '0;
      r_valid     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wr && !w_wrAccept;
      r_underflow <= rd && !w_rdAccept;
      if (IS_FRAME) begin
        case (r_state)
          FILL: begin
            r_valid <= w_validNext;
            r_count <= countOnes(w_validNext);
            if (w_startDrain) begin
              r_state <= DRAIN;
              r_len   <= frameLen(w_validNext);
              r_rPtr  <= '0;
            end
          end
          DRAIN: begin
            if (w_lastRead) begin
              r_valid <= '0;
              r_count <= '0;
              r_state <= FILL;
            end else if (w_rdAccept) begin
              r_rPtr <= r_rPtr + 1'b1;
            end
          end
        endcase
      end else begin
        if (w_wrAccept) r_wPtr <= r_wPtr + 1'b1;
        if (w_rdAccept) r_rPtr <= r_rPtr + 1'b1;
        r_count <= r_count + (ADDR_W+1)'(w_wrAccept) - (ADDR_W+1)'(w_rdAccept);
      end
    end
  end

  tx_buffer_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk    (clk),
    .i_we   (w_wrAccept),
    .i_waddr(w_memWaddr),
    .i_wdata(w_data),
    .i_raddr(r_rPtr),
    .o_rdata(w_memRdata)
  );

  assign r_data    = (w_empty || (IS_FRAME && !r_valid[r_rPtr])) ? '0 : w_memRdata;
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: doc/tx_fifo_buffer.md
TX_FIFO_BUFFER -- requirements
Module: tx_fifo_buffer

Interface
REQ-001 Parameter DATA_W, default 8, width of each data word in bits.
REQ-002 Parameter ADDR_W, default 2, index width; DEPTH = 2**ADDR_W.
REQ-003 Parameter FRAME_MODE, default 0; 0 = stream FIFO, 1 = addressed frame buffer.
REQ-004 Port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port wr, input, 1, write request for w_data.
REQ-007 Port w_data, input, DATA_W, write data.
REQ-008 Port address, input, ADDR_W, write slot in frame mode; ignored in stream mode.
REQ-009 Port commit, input, 1, frame mode only; releases a partial frame for draining.
REQ-010 Port rd, input, 1, consumer pop; acknowledges the current r_data.
REQ-011 Port r_data, output, DATA_W, head word (first-word-fall-through).
REQ-012 Port empty, output, 1, no word available to the reader.
REQ-013 Port full, output, 1, writes are not accepted this cycle.
REQ-014 Port count, output, ADDR_W+1, words currently held (stream) or slots written (frame).
REQ-015 Port overflow, output, 1, one-cycle pulse when a write was rejected.
REQ-016 Port underflow, output, 1, one-cycle pulse when a read was rejected.

Function
REQ-017 The block SHALL drive r_data = 0 whenever empty = 1, and the head word otherwise, combinationally from registered state.
REQ-018 The block SHALL register overflow and underflow, asserting each on the cycle after the offending request.
REQ-019 Stream mode: wr with full = 0 SHALL write mem[w_ptr], increment w_ptr modulo DEPTH, and increment count.
REQ-020 Stream mode: rd with empty = 0 SHALL increment r_ptr modulo DEPTH and decrement count.
REQ-021 Stream mode: simultaneous accepted wr and rd SHALL leave count unchanged and advance both pointers.
REQ-022 Stream mode: wr while full SHALL be accepted only if rd is also asserted in that cycle; otherwise it is dropped and overflow pulses.
REQ-023 Stream mode: rd while empty SHALL be ignored and underflow pulses; a simultaneous wr is still accepted.
REQ-024 Stream mode: full = (count == DEPTH) and empty = (count == 0).
REQ-025 Frame mode: the block SHALL use a two-state FSM, FILL and DRAIN.
REQ-026 FILL: the block SHALL hold empty = 1 and full = 0; wr writes mem[address] and sets valid[address]; count = number of set valid bits; rewriting a valid slot overwrites the data without changing count.
REQ-027 FILL -> DRAIN SHALL occur on the edge after all DEPTH valid bits are set, or on commit with count > 0; commit with count = 0 is ignored.
REQ-028 On entering DRAIN, the block SHALL latch frame length LEN = highest valid index + 1 and set r_ptr = 0.
REQ-029 DRAIN: empty = 0, full = 1; r_data = mem[r_ptr] if valid[r_ptr], else 0 (holes read as zero).
REQ-030 DRAIN: rd SHALL advance r_ptr; rd at r_ptr = LEN-1 SHALL clear all valid bits, set count = 0, and return to FILL on the next edge.
REQ-031 DRAIN: wr is rejected with an overflow pulse; commit is ignored.
REQ-032 FILL: rd is rejected with an underflow pulse.

Reset
REQ-033 While reset = 1 at a clock edge, the block SHALL clear w_ptr, r_ptr, count, LEN, all valid bits, overflow, and underflow, and set the state to FILL; this takes priority over wr, rd, and commit in the same cycle.
REQ-034 After reset, outputs SHALL be empty = 1, full = 0, count = 0, r_data = 0; mem contents are not reset.
REQ-035 A reset asserted mid-drain or mid-fill SHALL discard the frame or queue with no overflow or underflow pulse.

Structure
REQ-036 Package tx_fifo_buffer_pkg SHALL hold the FSM state type (FILL, DRAIN) and the mode constants MODE_STREAM = 0 and MODE_FRAME = 1.
REQ-037 Storage SHALL be a sub-module tx_buffer_mem: DEPTH x DATA_W, one synchronous write port and one asynchronous read port, with no reset.

Verification
REQ-038 Stream, defaults: write 0x11,0x22,0x33,0x44 -> full = 1, count = 4; a 5th wr -> overflow pulses once; reads return 0x11..0x44 in order, then empty = 1 and r_data = 0.
REQ-039 Stream: when full, simultaneous wr 0x55 and rd -> count stays 4, no overflow; after 6 wr/rd pairs, data order is preserved across pointer wrap.
REQ-040 Stream: rd while empty together with wr 0xA5 -> underflow pulses, count = 1, r_data = 0xA5 next cycle.
REQ-041 Frame: write addr 2 = 0xC3 and addr 0 = 0x3C, then commit -> DRAIN, LEN = 3; reads return 0x3C, 0x00, 0xC3, then FILL with empty = 1; wr during DRAIN -> overflow.
REQ-042 Frame: fill all 4 slots without commit -> automatic DRAIN; reset asserted after 2 reads -> FILL, count = 0, no flag pulses.
